pc_unit: RTL

//   Parametrised program-counter register for the single-cycle/pipelined MIPS core.

---
 rtl/pc_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit -- IF-stage program counter for the MIPS core.
//   Holds the fetch address, advances it by INC each unstalled cycle, takes
//   branch/jump redirects, and buffers one redirect that arrives while the
//   stage is stalled so it can be applied when the stall releases.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-high reset
//   stall            hold pc this cycle (hazard unit)
//   branch_taken     branch resolved taken this cycle
//   branch_target    branch destination
//   jump             jump decoded this cycle
//   jump_target      jump destination
//   pc               current fetch address (registered)
//   pc_seq           pc + INC, combinational, wraps mod 2^WIDTH
//   redirect_pending buffered redirect waiting for stall release (registered)
//   misalign         registered alignment flag for the loaded pc
//   fetch_count      count of cycles in which pc updated, saturating
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INC          = 4,
  parameter int unsigned      ALIGN_BITS   = 2,
  parameter int unsigned      CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             redirect_pending,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
  // Mask collapses to zero when ALIGN_BITS is 0, which disables the flag.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  typedef enum logic {
    RUN,
    PEND
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pend_target;
  logic [WIDTH-1:0] pend_target_next;
  logic [WIDTH-1:0] pc_next;
  logic             req;
  logic [WIDTH-1:0] tgt;

  // Branch is the older instruction, so it wins over a simultaneous jump.
  always_comb begin
    req = branch_taken | jump;
    tgt = branch_taken ? branch_target : jump_target;
  end

  // State register (with pc, buffer and alignment flag)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pend_target <= '0;
      pc          <= RESET_VECTOR;
      misalign    <= |(RESET_VECTOR & ALIGN_MASK);
    end else begin
      state       <= state_next;
      pend_target <= pend_target_next;
      pc          <= pc_next;
      misalign    <= |(pc_next & ALIGN_MASK);
    end
  end

  // Next-state logic. While stalled a new request overwrites any buffered
  // one; once unstalled the machine always returns to RUN, because either the
  // buffer is consumed or a live request supersedes it.
  always_comb begin
    state_next       = state;
    pend_target_next = pend_target;
    if (stall) begin
      if (req) begin
        state_next       = PEND;
        pend_target_next = tgt;
      end
    end else begin
      state_next = RUN;
    end
  end

  always_comb begin
    pc_next = pc;
    if (!stall) begin
      if (req) begin
        pc_next = tgt;
      end else if (state == PEND) begin
        pc_next = pend_target;
      end else begin
        pc_next = pc + INC_W;
      end
    end
  end

  // Output logic
  always_comb begin
    redirect_pending = (state == PEND);
    pc_seq           = pc + INC_W;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (!stall && (fetch_count != '1)) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule
